// File: rtl/sgmii_mgmt_pkg.sv
// Shared definitions for the SGMII MDIO management sequencer: register map,
// Clause 22 opcodes, control/status constants and the sequencer state encoding.
package sgmii_mgmt_pkg;

    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_STAT = 5'd1;
    localparam logic [4:0] REG_ADV  = 5'd4;
    localparam logic [4:0] REG_LP   = 5'd5;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam logic [15:0] CTRL_AN_RESTART  = 16'h1200;
    localparam int          STAT_AN_CMPL_BIT = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADV,
        ST_WR_CTRL,
        ST_WAIT,
        ST_RD_STAT,
        ST_RD_LP,
        ST_DONE
    } an_state_e;

    // States that own an MDIO transaction for their whole duration
    function automatic logic is_frame_state(an_state_e s);
        return (s == ST_WR_ADV) || (s == ST_WR_CTRL) || (s == ST_RD_STAT) || (s == ST_RD_LP);
    endfunction

endpackage

// File: rtl/sgmii_mdio_frame.sv
// Clause 22 MDIO frame engine: MDC divider, 64-bit shift-out, read sampling.
// One frame per go pulse; done strobes with rdata registered on the final MDC fall.
module sgmii_mdio_frame
    import sgmii_mgmt_pkg::*;
#(
    parameter int MDC_DIV = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        rd,
    input  logic [4:0]  phyad,
    input  logic [4:0]  regad,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [15:0] rdata,
    output logic        mdc,
    output logic        mdout,
    output logic        mdout_en,
    input  logic        mdin
);

    localparam int DW = $clog2(MDC_DIV);

    logic          active;
    logic          rd_q;
    logic [DW-1:0] div_cnt;
    logic [6:0]    hcnt;
    logic [63:0]   sh;
    logic [15:0]   rsh;
    logic [63:0]   frame;
    logic [5:0]    nxt_bit;
    logic          half_tick;

    // Read frames fill TA and data with ones; the line is released there anyway
    assign frame = {32'hFFFF_FFFF, 2'b01, (rd ? OP_RD : OP_WR), phyad, regad,
                    (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wdata)};

    assign half_tick = active && (div_cnt == DW'(MDC_DIV - 1));
    assign nxt_bit   = hcnt[6:1] + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            rd_q     <= 1'b0;
            div_cnt  <= '0;
            hcnt     <= '0;
            sh       <= '1;
            rsh      <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            mdc      <= 1'b0;
            mdout    <= 1'b1;
            mdout_en <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go && !active) begin
                active   <= 1'b1;
                rd_q     <= rd;
                div_cnt  <= '0;
                hcnt     <= '0;
                sh       <= frame;
                mdc      <= 1'b0;
                mdout    <= frame[63];
                mdout_en <= 1'b1;
            end else if (half_tick) begin
                div_cnt <= '0;
                hcnt    <= hcnt + 7'd1;
                mdc     <= ~mdc;
                if (!mdc) begin
                    rsh <= {rsh[14:0], mdin};
                end else if (hcnt == 7'd127) begin
                    active   <= 1'b0;
                    done     <= 1'b1;
                    mdout    <= 1'b1;
                    mdout_en <= 1'b0;
                    if (rd_q)
                        rdata <= rsh;
                end else begin
                    sh    <= {sh[62:0], 1'b1};
                    mdout <= sh[62];
                    // Both TA bits and the data of a read belong to the PHY
                    if (rd_q && nxt_bit >= 6'd46)
                        mdout_en <= 1'b0;
                end
            end else if (active) begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sgmii_an_sequencer.sv
// SGMII autonegotiation bring-up over MDIO: programs advertisement, restarts AN,
// then polls status, fetches link-partner ability and keeps monitoring for AN loss.
module sgmii_an_sequencer
    import sgmii_mgmt_pkg::*;
#(
    parameter int MDC_DIV       = 25,
    parameter int POLL_INTERVAL = 125000,
    parameter int MAX_POLLS     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        restart_an,
    input  logic [4:0]  port_id,
    input  logic [15:0] adv_ability,
    output logic        mdc,
    output logic        mdout,
    output logic        mdout_en,
    input  logic        mdin,
    output logic        busy,
    output logic        an_done,
    output logic [15:0] lp_ability,
    output logic        timeout_err
);

    localparam int IW = $clog2(POLL_INTERVAL + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);

    an_state_e      state, state_nxt;
    logic [15:0]    adv_q;
    logic [IW-1:0]  ivl_cnt;
    logic [PW-1:0]  poll_cnt;
    logic           pend;

    logic           go, f_rd, f_done;
    logic [4:0]     f_regad;
    logic [15:0]    f_wdata, f_rdata;
    logic           stat_cmpl;

    logic           an_set, an_clr, poll_inc, poll_rst, tmo, lp_ld;

    assign stat_cmpl = f_rdata[STAT_AN_CMPL_BIT];

    always_comb begin
        state_nxt = state;
        an_set    = 1'b0;
        an_clr    = 1'b0;
        poll_inc  = 1'b0;
        poll_rst  = 1'b0;
        tmo       = 1'b0;
        lp_ld     = 1'b0;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_WR_ADV;
            ST_WR_ADV:  if (f_done) state_nxt = ST_WR_CTRL;
            ST_WR_CTRL: if (f_done) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (restart_an) begin
                    state_nxt = ST_WR_CTRL;
                    an_clr    = 1'b1;
                end else if (ivl_cnt == IW'(POLL_INTERVAL - 1)) begin
                    state_nxt = ST_RD_STAT;
                end
            end
            ST_RD_STAT: begin
                if (f_done) begin
                    if (stat_cmpl) begin
                        poll_rst  = 1'b1;
                        state_nxt = an_done ? ST_DONE : ST_RD_LP;
                    end else begin
                        an_clr = 1'b1;
                        if (poll_cnt == PW'(MAX_POLLS - 1)) begin
                            tmo       = 1'b1;
                            state_nxt = ST_WR_CTRL;
                        end else begin
                            poll_inc  = 1'b1;
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_RD_LP: begin
                if (f_done) begin
                    lp_ld     = 1'b1;
                    an_set    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart_an) begin
                    state_nxt = ST_WR_CTRL;
                    an_clr    = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A restart requested mid-transaction diverts the next entry into WAIT
        if (state_nxt == ST_WAIT && state != ST_WAIT && pend) begin
            state_nxt = ST_WR_CTRL;
            an_clr    = 1'b1;
        end

        // Frames launch on the same edge as the state change to avoid dead cycles
        go      = is_frame_state(state_nxt) && (state_nxt != state);
        f_rd    = (state_nxt == ST_RD_STAT) || (state_nxt == ST_RD_LP);
        f_regad = REG_CTRL;
        f_wdata = '0;
        case (state_nxt)
            ST_WR_ADV: begin
                f_regad = REG_ADV;
                f_wdata = (state == ST_IDLE) ? adv_ability : adv_q;
            end
            ST_WR_CTRL: begin
                f_regad = REG_CTRL;
                f_wdata = CTRL_AN_RESTART;
            end
            ST_RD_STAT: f_regad = REG_STAT;
            ST_RD_LP:   f_regad = REG_LP;
            default:    f_regad = REG_CTRL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            adv_q       <= '0;
            ivl_cnt     <= '0;
            poll_cnt    <= '0;
            pend        <= 1'b0;
            busy        <= 1'b0;
            an_done     <= 1'b0;
            lp_ability  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= tmo;
            if (state == ST_IDLE && start) begin
                adv_q <= adv_ability;
                busy  <= 1'b1;
            end
            ivl_cnt <= (state == ST_WAIT) ? ivl_cnt + 1'b1 : '0;
            if ((go && state_nxt == ST_WR_CTRL) || poll_rst)
                poll_cnt <= '0;
            else if (poll_inc)
                poll_cnt <= poll_cnt + 1'b1;
            if (restart_an && state != ST_WAIT && state != ST_DONE)
                pend <= 1'b1;
            else if (go && state_nxt == ST_WR_CTRL)
                pend <= 1'b0;
            if (an_set)
                an_done <= 1'b1;
            else if (an_clr)
                an_done <= 1'b0;
            if (lp_ld)
                lp_ability <= f_rdata;
        end
    end

    sgmii_mdio_frame #(
        .MDC_DIV (MDC_DIV)
    ) u_frame (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .rd       (f_rd),
        .phyad    (port_id),
        .regad    (f_regad),
        .wdata    (f_wdata),
        .done     (f_done),
        .rdata    (f_rdata),
        .mdc      (mdc),
        .mdout    (mdout),
        .mdout_en (mdout_en),
        .mdin     (mdin)
    );

endmodule

// File: tb/tb_sgmii_an_sequencer.sv
// Directed bench: decodes every MDIO frame bit by bit, acts as a PHY slave on
// reads, and checks sequencing, timing, timeout, AN loss, restart and reset.
module tb_sgmii_an_sequencer;

    localparam int MDC_DIV = 2;
    localparam int POLL    = 20;
    localparam int MAXP    = 3;
    localparam int CLK_P   = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        restart_an = 1'b0;
    logic [4:0]  port_id = 5'h03;
    logic [15:0] adv_ability = 16'h4001;
    logic        mdc, mdout, mdout_en;
    logic        mdin = 1'b1;
    logic        busy, an_done, timeout_err;
    logic [15:0] lp_ability;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_tmo = 0;
    int          n_lp_rd = 0;
    logic [15:0] stat_val = 16'h0000;
    logic [15:0] lp_val = 16'hD801;
    time         t_end = 0;

    logic [63:0] fr;
    int          len, first_rise, gap;
    bit          en_ok;

    always #(CLK_P / 2) clk = ~clk;

    always @(negedge clk) if (timeout_err) n_tmo++;

    sgmii_an_sequencer #(
        .MDC_DIV       (MDC_DIV),
        .POLL_INTERVAL (POLL),
        .MAX_POLLS     (MAXP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .restart_an  (restart_an),
        .port_id     (port_id),
        .adv_ability (adv_ability),
        .mdc         (mdc),
        .mdout       (mdout),
        .mdout_en    (mdout_en),
        .mdin        (mdin),
        .busy        (busy),
        .an_done     (an_done),
        .lp_ability  (lp_ability),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture one frame; pulse restart_an after rise pulse_bit, assert reset after rise rst_bit
    task automatic get_frame(input int pulse_bit, input int rst_bit);
        int   t, nr;
        logic pm, isrd, pdone, exp_en;
        logic [4:0]  rg;
        logic [15:0] rv;
        fr = '0; len = 0; first_rise = 0; en_ok = 1'b1; nr = 0;
        isrd = 1'b0; pdone = 1'b0; rg = '0; rv = '0; mdin = 1'b1; t = 0;
        while (!mdout_en && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!mdout_en) begin
            chk("launch_timeout", 64'd0, 64'd1);
            return;
        end
        gap = int'(($time - t_end) / CLK_P);
        pm = mdc;
        for (int c = 1; c <= 400; c++) begin
            restart_an = (pulse_bit > 0 && nr == pulse_bit && !pdone);
            if (restart_an) pdone = 1'b1;
            @(negedge clk);
            if (mdc && !pm) begin
                nr++;
                if (nr == 1) first_rise = c;
                fr = {fr[62:0], mdout};
                exp_en = !(isrd && nr >= 47);
                if (mdout_en !== exp_en) en_ok = 1'b0;
                if (nr == 36) isrd = (fr[1:0] == 2'b10);
                if (nr == 46) begin
                    rg = fr[4:0];
                    rv = (rg == 5'd1) ? stat_val : ((rg == 5'd5) ? lp_val : 16'h0000);
                    if (isrd && rg == 5'd5) n_lp_rd++;
                end
                if (nr >= 48 && nr <= 63) mdin = rv[15 - (nr - 48)];
                if (nr == rst_bit) begin
                    restart_an = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    return;
                end
            end else if (!mdc && pm && nr == 64) begin
                len = c;
                if (mdout_en !== 1'b0) en_ok = 1'b0;
                t_end = $time;
                break;
            end
            pm = mdc;
        end
        restart_an = 1'b0;
        mdin = 1'b1;
        if (nr != 64) chk("frame_timeout", 64'(nr), 64'd64);
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] rg, input logic [15:0] d);
        get_frame(-1, -1);
        chk({tag, "_hdr"}, {16'h0, fr[63:16]}, {16'h0, 32'hFFFF_FFFF, 2'b01, 2'b01, 5'h03, rg, 2'b10});
        chk({tag, "_data"}, 64'(fr[15:0]), 64'(d));
        chk({tag, "_len"}, 64'(len), 64'd256);
        chk({tag, "_en"}, 64'(en_ok), 64'd1);
    endtask

    task automatic expect_rd(input string tag, input logic [4:0] rg, input int pulse_bit);
        get_frame(pulse_bit, -1);
        chk({tag, "_hdr"}, {18'h0, fr[63:18]}, {18'h0, 32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, rg});
        chk({tag, "_en"}, 64'(en_ok), 64'd1);
    endtask

    initial begin
        #23;
        chk("rst_mdc", 64'(mdc), 64'd0);
        chk("rst_mdout", 64'(mdout), 64'd1);
        chk("rst_en", 64'(mdout_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_an_done", 64'(an_done), 64'd0);
        chk("rst_lp", 64'(lp_ability), 64'd0);
        chk("rst_tmo", 64'(timeout_err), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("busy", 64'(busy), 64'd1);
        expect_wr("f1_adv", 5'd4, 16'h4001);
        chk("f1_first_rise", 64'(first_rise), 64'(MDC_DIV));
        expect_wr("f2_ctrl", 5'd0, 16'h1200);
        chk("f2_gap", 64'(gap), 64'd1);

        stat_val = 16'h0000;
        expect_rd("f3_stat", 5'd1, -1);
        chk("f3_gap", 64'(gap), 64'(POLL + 1));
        expect_rd("f4_stat", 5'd1, -1);
        chk("no_tmo_yet", 64'(n_tmo), 64'd0);
        expect_rd("f5_stat", 5'd1, -1);
        expect_wr("f6_reissue", 5'd0, 16'h1200);
        chk("f6_gap", 64'(gap), 64'd1);
        chk("tmo_once", 64'(n_tmo), 64'd1);

        expect_rd("f7_stat", 5'd1, -1);
        expect_rd("f8_stat", 5'd1, -1);
        stat_val = 16'h0020;
        expect_rd("f9_stat", 5'd1, -1);
        chk("an_pre", 64'(an_done), 64'd0);
        expect_rd("f10_lp", 5'd5, -1);
        @(negedge clk);
        chk("an_rise", 64'(an_done), 64'd1);
        chk("lp_val", 64'(lp_ability), 64'hD801);
        expect_rd("f11_stat", 5'd1, -1);
        chk("an_hold", 64'(an_done), 64'd1);

        stat_val = 16'h0000;
        expect_rd("f12_stat", 5'd1, -1);
        @(negedge clk);
        chk("an_fall", 64'(an_done), 64'd0);
        chk("lp_kept", 64'(lp_ability), 64'hD801);

        expect_rd("f13_stat_rst", 5'd1, 20);
        expect_wr("f14_restart", 5'd0, 16'h1200);
        chk("f14_gap", 64'(gap), 64'd1);
        chk("lp_reads", 64'(n_lp_rd), 64'd1);
        chk("tmo_total", 64'(n_tmo), 64'd1);

        expect_rd("f15_stat_rst", 5'd1, 10);
        get_frame(-1, 41);
        chk("f16_partial", {23'h0, fr[40:0]}, {23'h0, 32'hFFFF_FFFF, 2'b01, 2'b01, 5'h03});
        chk("arst_mdc", 64'(mdc), 64'd0);
        chk("arst_en", 64'(mdout_en), 64'd0);
        chk("arst_mdout", 64'(mdout), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_lp", 64'(lp_ability), 64'd0);
        @(negedge clk); rst_n = 1'b1; mdin = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_en", 64'(mdout_en), 64'd0);

        adv_ability = 16'hA5C3;
        start = 1'b1; @(negedge clk); start = 1'b0;
        adv_ability = 16'h0000;
        expect_wr("f17_adv", 5'd4, 16'hA5C3);
        chk("f17_first_rise", 64'(first_rise), 64'(MDC_DIV));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sgmii_an_sequencer.md
# sgmii_an_sequencer

- MDIO (Clause 22) management master for one SGMII channel's SMI register interface.
- After `start`, it writes the advertised ability and enables and restarts autonegotiation.
- It then polls status until AN completes, reads the link-partner ability, and keeps polling to detect AN loss.
- It sits beside the SGMII channel wrapper and drives its `mdc`/`mdio` port, replacing manual MDIO configuration.

## Interface
Parameters:
- `MDC_DIV`, 25: clk cycles per MDC half-period (125 MHz → 2.5 MHz MDC); minimum 2.
- `POLL_INTERVAL`, 125000: clk cycles between status reads (1 ms at 125 MHz).
- `MAX_POLLS`, 1000: status reads without AN complete before AN is restarted.

Ports:
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins the sequence; sampled only in IDLE.
- `restart_an` in 1: single-cycle pulse; in POLL/DONE, forces a new WR_CTRL.
- `port_id` in 5: PHYAD placed in every frame.
- `adv_ability` in 16: value written to reg 4; sampled when `start` is accepted.
- `mdc` out 1: management clock; low whenever no frame is active.
- `mdout` out 1: serial data out.
- `mdout_en` out 1: output enable; 0 during the read TA/data phase and when idle.
- `mdin` in 1: serial data in.
- `busy` out 1: high from `start` acceptance until reset.
- `an_done` out 1: high while the last status read had bit 5 = 1.
- `lp_ability` out 16: last reg 5 value read.
- `timeout_err` out 1: one-cycle pulse when `MAX_POLLS` is exhausted.

## Operation
Main FSM states: IDLE, WR_ADV, WR_CTRL, WAIT, RD_STAT, RD_LP, DONE.
- IDLE + `start` → WR_ADV: write reg 4 = latched `adv_ability`.
- WR_ADV → WR_CTRL: write reg 0 = 16'h1200 (bit 12 AN enable, bit 9 restart); clear the poll counter.
- WR_CTRL → WAIT.
- WAIT: count `POLL_INTERVAL` cycles, then → RD_STAT.
- RD_STAT, status bit 5 = 1 and `an_done` was 0 → RD_LP.
- RD_STAT, bit 5 = 1 and `an_done` already 1 → DONE.
- RD_STAT, bit 5 = 0 → clear `an_done`, increment the poll counter.
  - If the counter reaches `MAX_POLLS`: pulse `timeout_err` → WR_CTRL.
  - Otherwise → WAIT.
- RD_LP: latch `lp_ability`, set `an_done` → DONE.
- DONE → WAIT (continuous monitoring). A drop of bit 5 clears `an_done` without `timeout_err` until the counter expires.
- `restart_an` in WAIT or DONE → WR_CTRL and clear `an_done`.
  - In any other state it is held pending and acted on at the next entry to WAIT.
- `start` outside IDLE is ignored.

Frame engine, every transaction:
- 32 preamble ones, ST = 01.
- OP = 01 (write) or 10 (read).
- PHYAD = `port_id`, REGAD (5 bits, MSB first).
- TA: write drives 10; read releases both TA bits.
- 16 data bits, MSB first.
- Total 64 bit periods.

## Timing
- Reset values: `mdc`=0, `mdout`=1, `mdout_en`=0, `busy`=0, `an_done`=0, `lp_ability`=0, `timeout_err`=0, FSM = IDLE.
- Bit period = 2×`MDC_DIV` clk cycles.
- `mdout` and `mdout_en` change only on the clk edge that drives `mdc` 1→0.
- `mdin` is sampled on the clk edge that drives `mdc` 0→1; data bit n is sampled on MDC rising edge 49+n (n = 0..15).
- The first `mdc` rising edge occurs `MDC_DIV` cycles after frame launch.
- Frame length is 128×`MDC_DIV` clk cycles, from launch to the done strobe.
- There is no idle gap between back-to-back frames beyond 1 clk.
- `mdout_en` is 0 from the falling edge that starts TA bit 1 of a read through the end of the frame.
- `mdout_en` returns to 0 in the same cycle the frame ends.
- Read data is registered on the done strobe. `an_done` and `lp_ability` update 1 cycle later.
- Asynchronous reset mid-frame takes all outputs to their reset values immediately.
  - No partial frame is resumed; the next `start` begins with a full preamble.

## Structure
- Shared package `sgmii_mgmt_pkg`:
  - register addresses REG_CTRL = 0, REG_STAT = 1, REG_ADV = 4, REG_LP = 5;
  - opcodes OP_WR = 2'b01, OP_RD = 2'b10;
  - constants CTRL_AN_RESTART = 16'h1200 and STAT_AN_CMPL_BIT = 5;
  - FSM state enum.
- Sub-module `sgmii_mdio_frame`: MDC divider, 64-bit shift and bit counter, TA/direction control.
  - Command interface: `go`, `rd`, `regad`, `wdata`.
  - Response: `done` pulse, `rdata`.
- The top level contains only the sequencing FSM, poll and interval counters, and pending-restart flag.

## Test plan
- `start`, `adv_ability`=16'h4001, `port_id`=5'h03, MDC_DIV=2:
  - first frame decodes as write PHYAD 3, REG 4, data 4001;
  - second frame as write REG 0, data 1200;
  - each frame lasts 256 clk.
- MDIO slave model returns reg 1 = 16'h0000 twice, then 16'h0020, and reg 5 = 16'hD801 → `an_done` rises and `lp_ability`=16'hD801; exactly one reg 5 read occurs.
- Slave never sets bit 5, `MAX_POLLS`=3 → `timeout_err` pulses after the 3rd status read, then a reg 0 write of 16'h1200 is reissued.
- In DONE the slave clears bit 5 → `an_done` falls within 1 cycle of the next status read's done strobe; `lp_ability` is unchanged.
- `restart_an` asserted mid-frame in RD_STAT → the frame completes intact, then the next frame is a REG 0 write without an intervening WAIT period.
- `rst_n` asserted at bit 40 of a write → `mdout_en`=0 and `mdc`=0 immediately; the next `start` yields a full 32-one preamble.
